// File: rtl/prim_ram_2p_arb.sv
// prim_ram_2p_arb
// Round-robin front end that lets NumReq clients share one port of a
// two-port RAM. A small tracker remembers which client issued each read
// still in flight, so each returned word is handed back to that client.
// ECC errors on routed responses are counted. A response that arrives
// with no read behind it, or a read whose response never shows up, sets
// a sticky protocol-error flag.
module prim_ram_2p_arb #(
  parameter int NumReq    = 4,
  parameter int Depth     = 512,
  parameter int Width     = 32,
  parameter int RdLatency = 1,
  parameter int SramAw    = $clog2(Depth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        write_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*Width-1:0]  wdata_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [Width-1:0]         rdata_o,
  output logic [1:0]               rerror_o,
  output logic                     mem_req_o,
  output logic                     mem_write_o,
  output logic [SramAw-1:0]        mem_addr_o,
  output logic [Width-1:0]         mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [Width-1:0]         mem_rdata_i,
  input  logic [1:0]               mem_rerror_i,
  input  logic                     err_clr_i,
  output logic [15:0]              err_cnt_o,
  output logic                     proto_err_o
);

  localparam int IdW = $clog2(NumReq);

  logic [IdW-1:0]                rr_ptr_q, rr_ptr_d;
  logic                          gnt_any;
  logic [IdW-1:0]                gnt_idx;
  logic [IdW:0]                  cand;
  logic [IdW-1:0]                cand_idx;
  logic [RdLatency-1:0]          trk_valid_q;
  logic [RdLatency-1:0][IdW-1:0] trk_id_q;
  logic                          head_valid;
  logic [IdW-1:0]                head_id;
  logic                          routed;
  logic [15:0]                   err_cnt_q;
  logic                          proto_err_q;

  // Pick the first requester at or after rr_ptr, wrapping; nothing during reset
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NumReq)) begin
        cand = cand - (IdW+1)'(NumReq);
      end
      cand_idx = cand[IdW-1:0];
      if (!gnt_any && req_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (rst_i) begin
      gnt_any = 1'b0;
    end
  end

  // One-hot grant and RAM-side mux driven straight from the winner
  always_comb begin
    gnt_o = '0;
    if (gnt_any) begin
      gnt_o[gnt_idx] = 1'b1;
    end
    mem_req_o   = gnt_any;
    mem_write_o = write_i[gnt_idx];
    mem_addr_o  = addr_i[int'(gnt_idx)*SramAw +: SramAw];
    mem_wdata_o = wdata_i[int'(gnt_idx)*Width +: Width];
  end

  // Pointer moves just past the winner; holds when nobody was granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      if (gnt_idx == IdW'(NumReq-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + IdW'(1);
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // In-flight read tracker: one stage per cycle of RAM read latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trk_valid_q <= '0;
      trk_id_q    <= '0;
    end else begin
      trk_valid_q[0] <= gnt_any & ~mem_write_o;
      trk_id_q[0]    <= gnt_idx;
      for (int i = 1; i < RdLatency; i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_id_q[i]    <= trk_id_q[i-1];
      end
    end
  end

  assign head_valid = trk_valid_q[RdLatency-1];
  assign head_id    = trk_id_q[RdLatency-1];
  assign routed     = mem_rvalid_i & head_valid & ~rst_i;

  // Hand the returning word to whichever client issued the read
  always_comb begin
    rvalid_o = '0;
    if (routed) begin
      rvalid_o[head_id] = 1'b1;
    end
    rdata_o  = mem_rdata_i;
    rerror_o = mem_rerror_i;
  end

  // Saturating ECC error counter; a clear beats a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= '0;
    end else if (routed && (mem_rerror_i != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Sticky flag for a response without a read, or a read without a response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
    end else if (err_clr_i) begin
      proto_err_q <= 1'b0;
    end else if (mem_rvalid_i != head_valid) begin
      proto_err_q <= 1'b1;
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_prim_ram_2p_arb.sv
// tb_prim_ram_2p_arb
// Drives prim_ram_2p_arb (four clients, two-cycle RAM) against a small
// behavioural RAM. A negedge monitor runs a reference arbiter, tracker
// and error model; expected read results are queued at grant time and
// consumed when the response is due.
module tb_prim_ram_2p_arb;

  localparam int NumReq    = 4;
  localparam int Depth     = 512;
  localparam int Width     = 32;
  localparam int RdLatency = 2;
  localparam int SramAw    = 9;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NumReq-1:0]        req_i;
  logic [NumReq-1:0]        write_i;
  logic [NumReq*SramAw-1:0] addr_i;
  logic [NumReq*Width-1:0]  wdata_i;
  logic [NumReq-1:0]        gnt_o;
  logic [NumReq-1:0]        rvalid_o;
  logic [Width-1:0]         rdata_o;
  logic [1:0]               rerror_o;
  logic                     mem_req_o;
  logic                     mem_write_o;
  logic [SramAw-1:0]        mem_addr_o;
  logic [Width-1:0]         mem_wdata_o;
  logic                     mem_rvalid_i;
  logic [Width-1:0]         mem_rdata_i;
  logic [1:0]               mem_rerror_i;
  logic                     err_clr_i;
  logic [15:0]              err_cnt_o;
  logic                     proto_err_o;

  logic       force_rvalid;
  logic       drop_resp;
  logic [1:0] err_val;

  int n_checks = 0;
  int n_fail   = 0;

  prim_ram_2p_arb #(
    .NumReq(NumReq), .Depth(Depth), .Width(Width), .RdLatency(RdLatency), .SramAw(SramAw)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rerror_o(rerror_o), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_rerror_i(mem_rerror_i), .err_clr_i(err_clr_i),
    .err_cnt_o(err_cnt_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM with a two-cycle read pipeline
  logic [Width-1:0] ram [Depth];
  logic             p1_v = 1'b0;
  logic             p2_v = 1'b0;
  logic [Width-1:0] p1_d = '0;
  logic [Width-1:0] p2_d = '0;

  always @(posedge clk_i) begin
    p1_v <= mem_req_o && !mem_write_o;
    if (mem_req_o && !mem_write_o) p1_d <= ram[mem_addr_o];
    if (mem_req_o && mem_write_o) ram[mem_addr_o] <= mem_wdata_o;
    p2_v <= p1_v;
    p2_d <= p1_d;
  end

  assign mem_rvalid_i = (p2_v & ~drop_resp) | force_rvalid;
  assign mem_rdata_i  = p2_d;
  assign mem_rerror_i = err_val;

  // Reference model state
  typedef struct {
    logic [NumReq-1:0] onehot;
    logic [Width-1:0]  data;
  } exp_t;

  exp_t             exp_q[$];
  logic [Width-1:0] ref_mem [Depth];
  int               m_ptr   = 0;
  logic [1:0]       m_v     = 2'b00;
  logic [15:0]      m_cnt   = 16'h0;
  logic             m_proto = 1'b0;

  // Monitor: compare every cycle against the reference model, then advance it
  always @(negedge clk_i) begin : monitor
    logic [NumReq-1:0] exp_gnt;
    logic [SramAw-1:0] a;
    logic              routed;
    exp_t              e;
    int                g;
    if (rst_i) begin
      checkOutput("gnt_in_reset", gnt_o, 0);
      checkOutput("rvalid_in_reset", rvalid_o, 0);
      checkOutput("mem_req_in_reset", mem_req_o, 0);
      m_ptr   = 0;
      m_v     = 2'b00;
      m_cnt   = 16'h0;
      m_proto = 1'b0;
      exp_q.delete();
    end else begin
      g = -1;
      for (int i = 0; i < NumReq; i++) begin
        if (g < 0 && req_i[(m_ptr + i) % NumReq]) g = (m_ptr + i) % NumReq;
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      checkOutput("gnt", gnt_o, exp_gnt);
      checkOutput("mem_req", mem_req_o, g >= 0);
      a = '0;
      if (g >= 0) begin
        a = addr_i[g*SramAw +: SramAw];
        checkOutput("mem_write", mem_write_o, write_i[g]);
        checkOutput("mem_addr", mem_addr_o, a);
        if (write_i[g]) begin
          checkOutput("mem_wdata", mem_wdata_o, wdata_i[g*Width +: Width]);
          ref_mem[a] = wdata_i[g*Width +: Width];
        end
      end
      checkOutput("err_cnt", err_cnt_o, m_cnt);
      checkOutput("proto_err", proto_err_o, m_proto);
      routed = m_v[1] && mem_rvalid_i;
      if (m_v[1]) begin
        e = exp_q.pop_front();
        if (mem_rvalid_i) begin
          checkOutput("rvalid", rvalid_o, e.onehot);
          checkOutput("rdata", rdata_o, e.data);
          checkOutput("rerror", rerror_o, err_val);
        end else begin
          checkOutput("rvalid_missing", rvalid_o, 0);
        end
      end else begin
        checkOutput("rvalid_idle", rvalid_o, 0);
      end
      if (err_clr_i) begin
        m_cnt   = 16'h0;
        m_proto = 1'b0;
      end else begin
        if (routed && err_val != 2'b00 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (mem_rvalid_i != m_v[1]) m_proto = 1'b1;
      end
      m_v[1] = m_v[0];
      m_v[0] = (g >= 0) && !write_i[g];
      if (g >= 0 && !write_i[g]) begin
        e.onehot = exp_gnt;
        e.data   = ref_mem[a];
        exp_q.push_back(e);
      end
      if (g >= 0) m_ptr = (g + 1) % NumReq;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one access from client k and hold it until granted
  task automatic applyStimulus(input int k, input logic wr, input logic [SramAw-1:0] a,
                               input logic [Width-1:0] d);
    int waited;
    waited = 0;
    req_i[k]                   = 1'b1;
    write_i[k]                 = wr;
    addr_i[k*SramAw +: SramAw] = a;
    wdata_i[k*Width +: Width]  = d;
    forever begin
      @(negedge clk_i);
      if (gnt_o[k]) break;
      waited++;
      if (waited > 32) begin
        checkOutput("gnt_timeout", gnt_o[k], 1);
        break;
      end
    end
    tick();
    req_i[k] = 1'b0;
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1; req_i = '0; write_i = '0; addr_i = '0; wdata_i = '0;
    err_clr_i = 1'b0; force_rvalid = 1'b0; drop_resp = 1'b0; err_val = 2'b00;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_err_cnt", err_cnt_o, 0);
    checkOutput("reset_proto", proto_err_o, 0);
    checkOutput("reset_gnt", gnt_o, 0);
    tick();

    // Fairness: all four writing, grants rotate from requester 0
    $display("[TB] fairness");
    for (int k = 0; k < NumReq; k++) begin
      addr_i[k*SramAw +: SramAw] = SramAw'(9'h40 + k);
      wdata_i[k*Width +: Width]  = 32'hF000_0000 + k;
    end
    write_i = '1;
    req_i   = '1;
    for (int i = 0; i < 8; i++) begin
      logic [NumReq-1:0] want;
      want = 4'b0001 << (i % 4);
      @(negedge clk_i);
      checkOutput("fair_gnt", gnt_o, want);
    end
    tick();
    req_i = '0;

    // Skip: pointer at 1, only requester 0 asking
    $display("[TB] skip");
    applyStimulus(0, 1'b1, 9'h000, 32'hC0DE_0000);
    req_i = 4'b0001; write_i = '1; addr_i[0 +: SramAw] = 9'h001;
    @(negedge clk_i);
    checkOutput("skip_gnt", gnt_o, 4'b0001);
    tick();
    req_i = 4'b1111;
    @(negedge clk_i);
    checkOutput("skip_ptr_gnt", gnt_o, 4'b0010);
    repeat (4) tick();
    req_i = '0;

    // Routing with two reads from different clients in flight
    $display("[TB] routing");
    applyStimulus(1, 1'b1, 9'h010, 32'hA5A5_0010);
    applyStimulus(1, 1'b1, 9'h011, 32'h5A5A_0011);
    req_i = 4'b0100; write_i = '0; addr_i[2*SramAw +: SramAw] = 9'h010;
    tick();
    req_i = 4'b0001; addr_i[0 +: SramAw] = 9'h011;
    tick();
    req_i = '0;
    @(negedge clk_i);
    checkOutput("route_rvalid_t2", rvalid_o, 4'b0100);
    checkOutput("route_rdata_t2", rdata_o, 32'hA5A5_0010);
    @(negedge clk_i);
    checkOutput("route_rvalid_t3", rvalid_o, 4'b0001);
    checkOutput("route_rdata_t3", rdata_o, 32'h5A5A_0011);
    tick();

    // ECC counting
    $display("[TB] ecc count");
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    err_val = 2'b01;
    for (int i = 0; i < 3; i++) applyStimulus(3, 1'b0, 9'h010, '0);
    repeat (3) tick();
    err_val = 2'b00;
    @(negedge clk_i);
    checkOutput("ecc_cnt_3", err_cnt_o, 16'd3);
    tick();

    // Saturation: sustained erroring reads from requester 0
    $display("[TB] ecc saturation");
    err_val = 2'b10;
    req_i = 4'b0001; write_i = '0; addr_i[0 +: SramAw] = 9'h000;
    repeat (65540) tick();
    req_i = '0;
    repeat (3) tick();
    @(negedge clk_i);
    checkOutput("ecc_saturate", err_cnt_o, 16'hFFFF);
    tick();

    // Clear arriving with an erroring response
    err_val = 2'b01;
    req_i = 4'b0001;
    tick();
    req_i = '0;
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    err_val = 2'b00;
    @(negedge clk_i);
    checkOutput("ecc_clear_wins", err_cnt_o, 16'h0);
    tick();

    // Spurious response
    $display("[TB] spurious");
    force_rvalid = 1'b1;
    @(negedge clk_i);
    checkOutput("spurious_rvalid", rvalid_o, 0);
    tick();
    force_rvalid = 1'b0;
    @(negedge clk_i);
    checkOutput("spurious_proto", proto_err_o, 1);
    repeat (5) tick();
    @(negedge clk_i);
    checkOutput("proto_sticky", proto_err_o, 1);
    tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    @(negedge clk_i);
    checkOutput("proto_cleared", proto_err_o, 0);
    tick();

    // Missing response
    $display("[TB] missing response");
    req_i = 4'b0010; write_i = '0; addr_i[1*SramAw +: SramAw] = 9'h010;
    tick();
    req_i = '0;
    tick();
    drop_resp = 1'b1;
    @(negedge clk_i);
    checkOutput("missing_rvalid", rvalid_o, 0);
    tick();
    drop_resp = 1'b0;
    @(negedge clk_i);
    checkOutput("missing_proto", proto_err_o, 1);
    tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

    // Reset while a read is in flight
    $display("[TB] reset mid-read");
    req_i = 4'b0001; write_i = '0; addr_i[0 +: SramAw] = 9'h011;
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < NumReq; k++) addr_i[k*SramAw +: SramAw] = 9'h010;
    req_i = 4'b1111;
    @(negedge clk_i);
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_mem_req", mem_req_o, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_ptr_gnt", gnt_o, 4'b0001);
    checkOutput("rst_drop_rvalid", rvalid_o, 0);
    repeat (4) tick();
    req_i = '0;
    repeat (4) tick();
    @(negedge clk_i);
    checkOutput("rst_proto", proto_err_o, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
